// File: rtl/soc_sram_sp_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM macro between NPORTS requesters,
// with locked sequences; optional stall/grant counters under SOC_SRAM_ARB_STATS_EN.
module soc_sram_sp_arbiter #(
  parameter int unsigned NPORTS  = 2,
  parameter int unsigned XLEN    = 32,
  parameter int unsigned WORD_AW = 10,
  localparam int unsigned SW     = XLEN / 8
) (
  input  logic                      ahb3_clk_i,
  input  logic                      ahb3_rst_i,
  input  logic [NPORTS-1:0]         req_i,
  input  logic [NPORTS-1:0]         lock_i,
  input  logic [NPORTS-1:0]         we_i,
  input  logic [NPORTS*WORD_AW-1:0] addr_i,
  input  logic [NPORTS*XLEN-1:0]    wdata_i,
  input  logic [NPORTS*SW-1:0]      sel_i,
  output logic [NPORTS-1:0]         gnt_o,
  output logic [NPORTS-1:0]         rvalid_o,
  output logic [XLEN-1:0]           rdata_o,
  output logic                      sram_ce_o,
  output logic                      sram_we_o,
  output logic [WORD_AW-1:0]        sram_waddr_o,
  output logic [XLEN-1:0]           sram_din_o,
  output logic [SW-1:0]             sram_sel_o,
`ifdef SOC_SRAM_ARB_STATS_EN
  input  logic                      stats_clr_i,
  output logic [31:0]               stall_cnt_o,
  output logic [31:0]               grant_cnt_o,
`endif
  input  logic [XLEN-1:0]           sram_dout_i
);

  localparam int unsigned PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  typedef enum logic {ARB, LOCKED} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]     lock_owner_q, lock_owner_d;
  logic [NPORTS-1:0] rvalid_q, rvalid_d;
  logic [NPORTS-1:0] gnt;
  logic [PW-1:0]     idx;
  logic              found;

  // Requests are ignored while reset is asserted, so grants are gated by it.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    lock_owner_d = lock_owner_q;
    gnt          = '0;
    found        = 1'b0;
    idx          = '0;
    if (ahb3_rst_i) begin
      if (state_q == ARB) begin
        for (int unsigned i = 0; i < NPORTS; i++) begin
          idx = PW'((32'(rr_ptr_q) + i) % NPORTS);
          if (!found && req_i[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            rr_ptr_d = PW'((32'(idx) + 1) % NPORTS);
            if (lock_i[idx]) begin
              state_d      = LOCKED;
              lock_owner_d = idx;
            end
          end
        end
      end else if (lock_i[lock_owner_q]) begin
        gnt[lock_owner_q] = req_i[lock_owner_q];
      end else begin
        state_d = ARB;
      end
    end
  end

  always_comb begin
    sram_we_o    = 1'b0;
    sram_waddr_o = '0;
    sram_din_o   = '0;
    sram_sel_o   = '0;
    for (int unsigned p = 0; p < NPORTS; p++) begin
      if (gnt[p]) begin
        sram_we_o    = we_i[p];
        sram_waddr_o = addr_i[p*WORD_AW +: WORD_AW];
        sram_din_o   = wdata_i[p*XLEN +: XLEN];
        sram_sel_o   = sel_i[p*SW +: SW];
      end
    end
  end

  assign rvalid_d  = gnt & ~we_i;
  assign gnt_o     = gnt;
  assign sram_ce_o = |gnt;
  assign rvalid_o  = rvalid_q;
  assign rdata_o   = sram_dout_i;

  always_ff @(posedge ahb3_clk_i or negedge ahb3_rst_i) begin
    if (!ahb3_rst_i) begin
      state_q      <= ARB;
      rr_ptr_q     <= '0;
      lock_owner_q <= '0;
      rvalid_q     <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      lock_owner_q <= lock_owner_d;
      rvalid_q     <= rvalid_d;
    end
  end

`ifdef SOC_SRAM_ARB_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] grant_cnt_q, grant_cnt_d;

  // Clear takes priority over increment; both counters saturate.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    grant_cnt_d = grant_cnt_q;
    if (stats_clr_i) begin
      stall_cnt_d = '0;
      grant_cnt_d = '0;
    end else begin
      if ((|(req_i & ~gnt)) && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
      if (sram_ce_o && (grant_cnt_q != '1))         grant_cnt_d = grant_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge ahb3_clk_i or negedge ahb3_rst_i) begin
    if (!ahb3_rst_i) begin
      stall_cnt_q <= '0;
      grant_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      grant_cnt_q <= grant_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign grant_cnt_o = grant_cnt_q;
`endif

  lock_owner_range_a: assert property (@(posedge ahb3_clk_i) disable iff (!ahb3_rst_i)
    32'(lock_owner_q) < NPORTS);

endmodule

// File: tb/tb_soc_sram_sp_arbiter.sv
// Self-checking bench for soc_sram_sp_arbiter: vector table, directed corner sequences
// and randomized traffic against an arbitration/memory reference model.
module tb_soc_sram_sp_arbiter;
  localparam int N  = 2;
  localparam int XL = 32;
  localparam int AW = 10;
  localparam int S  = XL / 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_i, lock_i, we_i;
  logic [N*AW-1:0] addr_i;
  logic [N*XL-1:0] wdata_i;
  logic [N*S-1:0]  sel_i;
  logic [N-1:0]    gnt_o, rvalid_o;
  logic [XL-1:0]   rdata_o;
  logic            sram_ce, sram_we;
  logic [AW-1:0]   sram_addr;
  logic [XL-1:0]   sram_din;
  logic [S-1:0]    sram_sel;
  logic [XL-1:0]   sram_dout;
`ifdef SOC_SRAM_ARB_STATS_EN
  logic            stats_clr;
  logic [31:0]     stall_cnt, grant_cnt;
`endif

  always #5 clk = ~clk;

  soc_sram_sp_arbiter #(.NPORTS(N), .XLEN(XL), .WORD_AW(AW)) dut (
    .ahb3_clk_i(clk), .ahb3_rst_i(rst_n),
    .req_i(req_i), .lock_i(lock_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .sel_i(sel_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .sram_ce_o(sram_ce), .sram_we_o(sram_we),
    .sram_waddr_o(sram_addr), .sram_din_o(sram_din), .sram_sel_o(sram_sel),
`ifdef SOC_SRAM_ARB_STATS_EN
    .stats_clr_i(stats_clr), .stall_cnt_o(stall_cnt), .grant_cnt_o(grant_cnt),
`endif
    .sram_dout_i(sram_dout)
  );

  // Behavioural single-port SRAM macro: byte-masked write, registered read data.
  logic [XL-1:0] sram_mem [0:(1<<AW)-1] = '{default: '0};
  always @(posedge clk) begin
    if (sram_ce) begin
      if (sram_we) begin
        for (int b = 0; b < S; b++)
          if (sram_sel[b]) sram_mem[sram_addr][b*8 +: 8] = sram_din[b*8 +: 8];
      end else begin
        sram_dout <= sram_mem[sram_addr];
      end
    end
  end

  // Reference model state
  logic [XL-1:0] ref_mem [0:(1<<AW)-1] = '{default: '0};
  int            m_rr;
  bit            m_locked;
  int            m_owner;
  logic [N-1:0]  m_rv;
  logic [XL-1:0] m_rdata;
  longint        m_stall, m_grant;

  int errors = 0;
  int checks = 0;

  logic [N-1:0]  gnt_seen, rvalid_seen;
  logic [XL-1:0] rdata_seen;
  logic [S-1:0]  sel_seen;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rr = 0; m_locked = 0; m_owner = 0; m_rv = '0; m_rdata = '0;
    m_stall = 0; m_grant = 0;
  endtask

  // Entered at posedge+1 with inputs driven; checks at the falling edge, leaves at next posedge+1.
  task automatic step();
    int            g;
    logic [N-1:0]  eg;
    logic [AW-1:0] a;
    logic [XL-1:0] wd;
    logic [S-1:0]  sl;
    #4;
    g = -1;
    if (!m_locked) begin
      for (int k = 0; k < N; k++)
        if (g < 0 && req_i[(m_rr + k) % N]) g = (m_rr + k) % N;
    end else if (lock_i[m_owner] && req_i[m_owner]) begin
      g = m_owner;
    end
    eg = '0;
    a = '0; wd = '0; sl = '0;
    if (g >= 0) begin
      eg[g] = 1'b1;
      a  = addr_i[g*AW +: AW];
      wd = wdata_i[g*XL +: XL];
      sl = sel_i[g*S +: S];
    end
    gnt_seen = gnt_o; rvalid_seen = rvalid_o; rdata_seen = rdata_o; sel_seen = sram_sel;
    chk("gnt", gnt_o, eg);
    chk("ce", sram_ce, g >= 0);
    chk("sram_we", sram_we, (g >= 0) ? we_i[g] : 1'b0);
    chk("sram_addr", sram_addr, a);
    chk("sram_din", sram_din, wd);
    chk("sram_sel", sram_sel, sl);
    chk("rvalid", rvalid_o, m_rv);
    if (m_rv != '0) chk("rdata", rdata_o, m_rdata);
`ifdef SOC_SRAM_ARB_STATS_EN
    chk("stall_cnt", stall_cnt, m_stall);
    chk("grant_cnt", grant_cnt, m_grant);
    if (stats_clr) begin
      m_stall = 0; m_grant = 0;
    end else begin
      if ((req_i & ~eg) != '0 && m_stall < 64'hFFFF_FFFF) m_stall++;
      if (g >= 0 && m_grant < 64'hFFFF_FFFF) m_grant++;
    end
`endif
    m_rv = '0;
    if (g >= 0) begin
      if (!we_i[g]) begin
        m_rv[g] = 1'b1;
        m_rdata = ref_mem[a];
      end else begin
        for (int b = 0; b < S; b++)
          if (sl[b]) ref_mem[a][b*8 +: 8] = wd[b*8 +: 8];
      end
    end
    if (!m_locked && g >= 0) begin
      m_rr = (g + 1) % N;
      if (lock_i[g]) begin m_locked = 1; m_owner = g; end
    end else if (m_locked && !lock_i[m_owner]) begin
      m_locked = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    req_i = '0; lock_i = '0; we_i = '0; addr_i = '0; wdata_i = '0; sel_i = '0;
`ifdef SOC_SRAM_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic port0(input logic we, input logic [AW-1:0] a, input logic [XL-1:0] d,
                       input logic [S-1:0] s);
    idle_inputs();
    req_i[0] = 1'b1; we_i[0] = we;
    addr_i[0 +: AW] = a; wdata_i[0 +: XL] = d; sel_i[0 +: S] = s;
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] lock;
    logic [N-1:0] gnt;
  } vec_t;
  vec_t tbl [12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{2'b11, 2'b00, 2'b01};
    tbl[1]  = '{2'b11, 2'b00, 2'b10};
    tbl[2]  = '{2'b11, 2'b00, 2'b01};
    tbl[3]  = '{2'b11, 2'b00, 2'b10};
    tbl[4]  = '{2'b01, 2'b00, 2'b01};
    tbl[5]  = '{2'b11, 2'b10, 2'b10};
    tbl[6]  = '{2'b11, 2'b10, 2'b10};
    tbl[7]  = '{2'b11, 2'b10, 2'b10};
    tbl[8]  = '{2'b01, 2'b00, 2'b00};
    tbl[9]  = '{2'b01, 2'b00, 2'b01};
    tbl[10] = '{2'b00, 2'b00, 2'b00};
    tbl[11] = '{2'b10, 2'b00, 2'b10};

    idle_inputs();
    rst_n = 1'b0;
    req_i = 2'b11;
    #3;
    chk("reset_gnt", gnt_o, 2'b00);
    chk("reset_ce", sram_ce, 1'b0);
    chk("reset_rvalid", rvalid_o, 2'b00);
    @(posedge clk); #1;
    idle_inputs();
    do_reset();

    for (int i = 0; i < 12; i++) begin
      idle_inputs();
      req_i = tbl[i].req; lock_i = tbl[i].lock;
      addr_i[0 +: AW] = AW'(i); addr_i[AW +: AW] = AW'(i + 16);
      step();
      chk("tbl_gnt", gnt_seen, tbl[i].gnt);
    end

    port0(1'b1, 10'h005, 32'hDEADBEEF, 4'hF); step();
    port0(1'b0, 10'h005, '0, 4'hF);           step();
    chk("read_gnt", gnt_seen, 2'b01);
    idle_inputs();                            step();
    chk("read_rvalid", rvalid_seen, 2'b01);
    chk("read_rdata", rdata_seen, 32'hDEADBEEF);

    port0(1'b1, 10'h003, 32'h11223344, 4'hF); step();
    port0(1'b1, 10'h003, 32'h0000AB00, 4'b0010); step();
    chk("bytewr_sel", sel_seen, 4'b0010);
    port0(1'b0, 10'h003, '0, 4'hF);           step();
    chk("bytewr_no_rvalid", rvalid_seen, 2'b00);
    idle_inputs();                            step();
    chk("bytewr_rvalid", rvalid_seen, 2'b01);
    chk("bytewr_rdata", rdata_seen, 32'h1122AB44);

    port0(1'b0, 10'h005, '0, 4'hF); step();
    req_i = 2'b11;
    chk("midrd_rvalid_pre", rvalid_o, 2'b01);
    rst_n = 1'b0;
    #1;
    chk("midrd_rvalid_rst", rvalid_o, 2'b00);
    chk("midrd_gnt_rst", gnt_o, 2'b00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    step();
    chk("midrd_first_gnt", gnt_seen, 2'b01);

`ifdef SOC_SRAM_ARB_STATS_EN
    idle_inputs();
    do_reset();
    req_i = 2'b11;
    for (int i = 0; i < 10; i++) step();
    chk("stats_grant10", grant_cnt, 32'd10);
    chk("stats_stall10", stall_cnt, 32'd10);
    idle_inputs();
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    chk("stats_grant_clr", grant_cnt, 32'd0);
    chk("stats_stall_clr", stall_cnt, 32'd0);
`endif

    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < N; p++) begin
        req_i[p]  = ($urandom_range(0, 3) != 0);
        lock_i[p] = ($urandom_range(0, 3) == 0);
        we_i[p]   = $urandom_range(0, 1);
        addr_i[p*AW +: AW] = AW'($urandom_range(0, 7));
        wdata_i[p*XL +: XL] = $urandom;
        sel_i[p*S +: S] = S'($urandom_range(1, (1 << S) - 1));
      end
`ifdef SOC_SRAM_ARB_STATS_EN
      stats_clr = ($urandom_range(0, 19) == 0);
`endif
      step();
    end
    idle_inputs();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
